// File: rtl/core_pkg.sv
// Shared types for the single-cycle core: writeback state, error causes and
// register-file address width.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } wb_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_EXEC  = 2'b01,
    ERR_ALIGN = 2'b10
  } err_cause_t;

endpackage

// File: rtl/register_file.sv
// Integer register file: two combinational read ports and one synchronous
// write port. Register 0 and out-of-range addresses always read zero.
module register_file
  import core_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic [DATA_W-1:0]     rd_data_b
);

  logic [DATA_W-1:0] mem_r [NUM_REGS];

  // Storage: cleared on reset, written only for non-zero in-range addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en && (wr_addr != {REG_ADDR_W{1'b0}}) && (int'(wr_addr) < NUM_REGS)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read ports: no write bypass, so same-cycle writes show up after the edge.
  always_comb begin
    rd_data_a = {DATA_W{1'b0}};
    rd_data_b = {DATA_W{1'b0}};
    if ((rd_addr_a != {REG_ADDR_W{1'b0}}) && (int'(rd_addr_a) < NUM_REGS)) begin
      rd_data_a = mem_r[rd_addr_a];
    end else begin
      rd_data_a = {DATA_W{1'b0}};
    end
    if ((rd_addr_b != {REG_ADDR_W{1'b0}}) && (int'(rd_addr_b) < NUM_REGS)) begin
      rd_data_b = mem_r[rd_addr_b];
    end else begin
      rd_data_b = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/writeback_pc_unit.sv
// Writeback stage of the single-cycle core: commits execute results to the
// register file, steps or redirects the PC, counts retirements and halts on faults.
module writeback_pc_unit
  import core_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter int                PC_STEP  = 4,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     sonuc,
  input  logic                  pc_update,
  input  logic                  we,
  input  logic                  hata,
  input  logic                  resume,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  output logic [DATA_W-1:0]     pc,
  output logic                  halted,
  output logic                  retire,
  output logic [DATA_W-1:0]     err_pc,
  output logic [1:0]            err_cause,
  output logic [31:0]           retire_cnt
);

  localparam logic [DATA_W-1:0] PC_INC = DATA_W'(PC_STEP);

  wb_state_t         state_r, next_state_s;
  err_cause_t        err_cause_r;
  logic [DATA_W-1:0] pc_r, err_pc_r;
  logic [31:0]       retire_cnt_r;
  logic              retire_r;
  logic              halted_s;
  logic              run_valid_s, misaligned_s;
  logic              fault_exec_s, fault_align_s, commit_s, resume_s, rf_we_s;

  // Commit decode: an execute fault outranks a misaligned branch target.
  always_comb begin
    run_valid_s   = (state_r == RUN) && instr_valid;
    misaligned_s  = pc_update && (sonuc[1:0] != 2'b00);
    fault_exec_s  = run_valid_s && hata;
    fault_align_s = run_valid_s && !hata && misaligned_s;
    commit_s      = run_valid_s && !hata && !misaligned_s;
    resume_s      = (state_r == HALT) && resume;
    rf_we_s       = commit_s && we;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = RUN;
      RUN: begin
        if (fault_exec_s || fault_align_s) begin
          next_state_s = HALT;
        end else begin
          next_state_s = RUN;
        end
      end
      HALT: begin
        if (resume) begin
          next_state_s = RUN;
        end else begin
          next_state_s = HALT;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    halted_s = 1'b0;
    case (state_r)
      HALT:    halted_s = 1'b1;
      default: halted_s = 1'b0;
    endcase
  end

  // PC, fault capture, retire pulse and counter. Resume skips the faulting instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r         <= RESET_PC;
      err_pc_r     <= {DATA_W{1'b0}};
      err_cause_r  <= ERR_NONE;
      retire_r     <= 1'b0;
      retire_cnt_r <= 32'd0;
    end else begin
      if (commit_s) begin
        pc_r         <= pc_update ? sonuc : (pc_r + PC_INC);
        retire_cnt_r <= retire_cnt_r + 32'd1;
      end else if (resume_s) begin
        pc_r <= err_pc_r + PC_INC;
      end
      if (fault_exec_s) begin
        err_pc_r    <= pc_r;
        err_cause_r <= ERR_EXEC;
      end else if (fault_align_s) begin
        err_pc_r    <= pc_r;
        err_cause_r <= ERR_ALIGN;
      end else if (resume_s) begin
        err_cause_r <= ERR_NONE;
      end
      retire_r <= commit_s;
    end
  end

  register_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_register_file (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (rf_we_s),
    .wr_addr   (rd_addr),
    .wr_data   (sonuc),
    .rd_addr_a (rs1_addr),
    .rd_addr_b (rs2_addr),
    .rd_data_a (rs1_data),
    .rd_data_b (rs2_data)
  );

  assign pc         = pc_r;
  assign halted     = halted_s;
  assign retire     = retire_r;
  assign err_pc     = err_pc_r;
  assign err_cause  = err_cause_r;
  assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_writeback_pc_unit.sv
// Directed self-checking bench for writeback_pc_unit: commit, x0 write, branch,
// misaligned target, execute fault/resume, stall, PC wrap and reset in HALT.
module tb_writeback_pc_unit;

  logic        clk = 1'b0;
  logic        rst, instr_valid, pc_update, we, hata, resume;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] sonuc;
  logic [31:0] rs1_data, rs2_data, pc, err_pc, retire_cnt;
  logic        halted, retire;
  logic [1:0]  err_cause;

  int tests_run    = 0;
  int tests_failed = 0;

  writeback_pc_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .sonuc(sonuc), .pc_update(pc_update), .we(we), .hata(hata), .resume(resume),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .halted(halted),
    .retire(retire), .err_pc(err_pc), .err_cause(err_cause), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_valid = 1'b0; pc_update = 1'b0; we = 1'b0; hata = 1'b0; resume = 1'b0;
    rd_addr = 5'd0; sonuc = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); rs1_addr = 5'd3; rs2_addr = 5'd0;
    step(); step();
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    tests_run++; if (halted !== 1'b0 || retire !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: halted %b retire %b want 0 0", halted, retire); end
    tests_run++; if (err_pc !== 32'h0 || err_cause !== 2'b00) begin tests_failed++; $display("FAIL reset_err: err_pc %h cause %b want 0 00", err_pc, err_cause); end
    tests_run++; if (retire_cnt !== 32'd0 || rs1_data !== 32'h0) begin tests_failed++; $display("FAIL reset_cnt_reg: cnt %0d reg3 %h want 0 0", retire_cnt, rs1_data); end
    // First commit: one IDLE cycle, then the write and PC step.
    rst = 1'b0; instr_valid = 1'b1; we = 1'b1; rd_addr = 5'd3; sonuc = 32'h1234;
    step();
    tests_run++; if (pc !== 32'h0 || retire !== 1'b0) begin tests_failed++; $display("FAIL idle_no_commit: pc %h retire %b want 0 0", pc, retire); end
    step();
    tests_run++; if (pc !== 32'h4) begin tests_failed++; $display("FAIL first_pc: got %h want %h", pc, 32'h4); end
    tests_run++; if (rs1_data !== 32'h1234) begin tests_failed++; $display("FAIL first_write: got %h want %h", rs1_data, 32'h1234); end
    tests_run++; if (retire !== 1'b1 || retire_cnt !== 32'd1) begin tests_failed++; $display("FAIL first_retire: retire %b cnt %0d want 1 1", retire, retire_cnt); end
    idle_inputs();
    step();
    tests_run++; if (retire !== 1'b0) begin tests_failed++; $display("FAIL retire_pulse: got %b want 0", retire); end
  endtask

  task automatic test_write_x0();
    instr_valid = 1'b1; we = 1'b1; rd_addr = 5'd0; sonuc = 32'hFFFF_FFFF; rs1_addr = 5'd0;
    step();
    idle_inputs();
    tests_run++; if (rs1_data !== 32'h0) begin tests_failed++; $display("FAIL x0_read: got %h want 0", rs1_data); end
    tests_run++; if (pc !== 32'h8 || retire_cnt !== 32'd2) begin tests_failed++; $display("FAIL x0_commit: pc %h cnt %0d want 8 2", pc, retire_cnt); end
  endtask

  task automatic test_branch();
    instr_valid = 1'b1; pc_update = 1'b1; we = 1'b0; rd_addr = 5'd3; sonuc = 32'h40; rs1_addr = 5'd3;
    step();
    idle_inputs();
    tests_run++; if (pc !== 32'h40 || retire_cnt !== 32'd3) begin tests_failed++; $display("FAIL branch_pc: pc %h cnt %0d want 40 3", pc, retire_cnt); end
    tests_run++; if (rs1_data !== 32'h1234) begin tests_failed++; $display("FAIL branch_noreg: got %h want %h", rs1_data, 32'h1234); end
  endtask

  task automatic test_misaligned();
    instr_valid = 1'b1; pc_update = 1'b1; we = 1'b1; rd_addr = 5'd4; sonuc = 32'h42; rs1_addr = 5'd4;
    step();
    idle_inputs();
    tests_run++; if (halted !== 1'b1 || err_cause !== 2'b10) begin tests_failed++; $display("FAIL align_halt: halted %b cause %b want 1 10", halted, err_cause); end
    tests_run++; if (err_pc !== 32'h40 || pc !== 32'h40) begin tests_failed++; $display("FAIL align_pc: err_pc %h pc %h want 40 40", err_pc, pc); end
    tests_run++; if (retire_cnt !== 32'd3 || retire !== 1'b0 || rs1_data !== 32'h0) begin tests_failed++; $display("FAIL align_nocommit: cnt %0d retire %b reg4 %h want 3 0 0", retire_cnt, retire, rs1_data); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    tests_run++; if (pc !== 32'h44 || halted !== 1'b0 || err_cause !== 2'b00) begin tests_failed++; $display("FAIL align_resume: pc %h halted %b cause %b want 44 0 00", pc, halted, err_cause); end
    // Write plus redirect in one instruction, landing on 0x10.
    instr_valid = 1'b1; pc_update = 1'b1; we = 1'b1; rd_addr = 5'd6; sonuc = 32'h10; rs2_addr = 5'd6;
    step();
    idle_inputs();
    tests_run++; if (pc !== 32'h10 || rs2_data !== 32'h10 || retire_cnt !== 32'd4) begin tests_failed++; $display("FAIL write_and_branch: pc %h reg6 %h cnt %0d want 10 10 4", pc, rs2_data, retire_cnt); end
  endtask

  task automatic test_exec_fault_resume();
    instr_valid = 1'b1; hata = 1'b1; we = 1'b1; rd_addr = 5'd5; sonuc = 32'hDEAD; rs1_addr = 5'd5;
    step();
    tests_run++; if (halted !== 1'b1 || err_cause !== 2'b01 || err_pc !== 32'h10) begin tests_failed++; $display("FAIL exec_halt: halted %b cause %b err_pc %h want 1 01 10", halted, err_cause, err_pc); end
    tests_run++; if (rs1_data !== 32'h0 || pc !== 32'h10 || retire_cnt !== 32'd4) begin tests_failed++; $display("FAIL exec_nocommit: reg5 %h pc %h cnt %0d want 0 10 4", rs1_data, pc, retire_cnt); end
    // HALT ignores instr_valid, we and pc_update.
    hata = 1'b0; pc_update = 1'b1; sonuc = 32'h80;
    for (int i = 0; i < 3; i++) step();
    idle_inputs();
    tests_run++; if (halted !== 1'b1 || pc !== 32'h10 || rs1_data !== 32'h0 || retire_cnt !== 32'd4) begin tests_failed++; $display("FAIL halt_hold: halted %b pc %h reg5 %h cnt %0d want 1 10 0 4", halted, pc, rs1_data, retire_cnt); end
    resume = 1'b1;
    step();
    tests_run++; if (pc !== 32'h14 || halted !== 1'b0 || err_cause !== 2'b00 || err_pc !== 32'h10) begin tests_failed++; $display("FAIL exec_resume: pc %h halted %b cause %b err_pc %h want 14 0 00 10", pc, halted, err_cause, err_pc); end
    step();
    resume = 1'b0;
    tests_run++; if (pc !== 32'h14 || halted !== 1'b0) begin tests_failed++; $display("FAIL resume_in_run: pc %h halted %b want 14 0", pc, halted); end
  endtask

  task automatic test_stall();
    instr_valid = 1'b0; we = 1'b1; rd_addr = 5'd7; sonuc = 32'h55; pc_update = 1'b1; rs2_addr = 5'd7;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++; if (pc !== 32'h14 || retire_cnt !== 32'd4 || retire !== 1'b0 || rs2_data !== 32'h0) begin tests_failed++; $display("FAIL stall_%0d: pc %h cnt %0d retire %b reg7 %h want 14 4 0 0", i, pc, retire_cnt, retire, rs2_data); end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    instr_valid = 1'b1; pc_update = 1'b1; sonuc = 32'hFFFF_FFFC;
    step();
    tests_run++; if (pc !== 32'hFFFF_FFFC || retire_cnt !== 32'd5) begin tests_failed++; $display("FAIL preload_pc: pc %h cnt %0d want fffffffc 5", pc, retire_cnt); end
    pc_update = 1'b0; we = 1'b1; rd_addr = 5'd31; sonuc = 32'hA5; rs2_addr = 5'd31;
    step();
    idle_inputs();
    tests_run++; if (pc !== 32'h0 || retire_cnt !== 32'd6 || rs2_data !== 32'hA5) begin tests_failed++; $display("FAIL pc_wrap: pc %h cnt %0d reg31 %h want 0 6 a5", pc, retire_cnt, rs2_data); end
  endtask

  task automatic test_reset_in_halt();
    instr_valid = 1'b1; hata = 1'b1;
    step();
    tests_run++; if (halted !== 1'b1 || err_cause !== 2'b01) begin tests_failed++; $display("FAIL halt_before_rst: halted %b cause %b want 1 01", halted, err_cause); end
    rst = 1'b1; resume = 1'b1; hata = 1'b0; we = 1'b1; rd_addr = 5'd8; sonuc = 32'h99; rs1_addr = 5'd3;
    step();
    tests_run++; if (pc !== 32'h0 || halted !== 1'b0 || retire !== 1'b0 || retire_cnt !== 32'd0) begin tests_failed++; $display("FAIL rst_halt_core: pc %h halted %b retire %b cnt %0d want 0 0 0 0", pc, halted, retire, retire_cnt); end
    tests_run++; if (err_pc !== 32'h0 || err_cause !== 2'b00) begin tests_failed++; $display("FAIL rst_halt_err: err_pc %h cause %b want 0 00", err_pc, err_cause); end
    tests_run++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin tests_failed++; $display("FAIL rst_halt_regs: reg3 %h reg31 %h want 0 0", rs1_data, rs2_data); end
    rst = 1'b0; idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_write_x0();
    test_branch();
    test_misaligned();
    test_exec_fault_resume();
    test_stall();
    test_wrap();
    test_reset_in_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/writeback_pc_unit.md
Name: writeback_pc_unit

Overview:
- Consumer end of the execute interface in the single-cycle core.
- Takes the execute outputs sonuc, pc_update, we and hata and commits them at the clock edge: it writes the register file, advances or redirects the PC, and counts retired instructions.
- Also supplies rs1_data/rs2_data to execute through combinational register reads.
- Stops the core in a HALT state on an execute fault or a misaligned branch target.

Parameters:
- DATA_W, 32, datapath and PC width.
- NUM_REGS, 32, register count; register 0 is hard-wired to zero.
- PC_STEP, 4, sequential PC increment.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction memory presents a valid instruction this cycle.
- rs1_addr  in  5  read port 1 address.
- rs2_addr  in  5  read port 2 address.
- rd_addr  in  5  write address.
- sonuc  in  DATA_W  rd write data, or absolute branch target when pc_update=1.
- pc_update  in  1  branch taken.
- we  in  1  write rd.
- hata  in  1  execute fault.
- resume  in  1  leave HALT.
- rs1_data  out  DATA_W  combinational read of rs1_addr.
- rs2_data  out  DATA_W  combinational read of rs2_addr.
- pc  out  DATA_W  current PC.
- halted  out  1  state == HALT.
- retire  out  1  one-cycle pulse per committed instruction.
- err_pc  out  DATA_W  PC of the faulting instruction.
- err_cause  out  2  00 none, 01 execute fault, 10 misaligned target.
- retire_cnt  out  32  retired-instruction counter.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - pc=RESET_PC, halted=0, retire=0, err_pc=0, err_cause=00, retire_cnt=0.
  - All registers=0.
  - state=IDLE.
- State transitions:
  - IDLE → RUN unconditionally after one cycle. No commit in IDLE.
- RUN, instr_valid=1, the first matching rule applies:
  - hata=1: no register write; pc held; err_pc<=pc; err_cause<=01; → HALT; retire=0.
  - pc_update=1 and sonuc[1:0]!=0: no write; pc held; err_pc<=pc; err_cause<=10; → HALT; retire=0.
  - Otherwise, commit:
    - If we=1 and rd_addr!=0 and rd_addr<NUM_REGS, then reg[rd_addr]<=sonuc.
    - pc <= pc_update ? sonuc : pc+PC_STEP, mod 2^DATA_W (wraps).
    - retire=1 next cycle; retire_cnt+1, wrapping at 2^32.
- RUN, instr_valid=0: hold all state; retire=0.
- we=1 together with pc_update=1 is legal: both the write and the redirect occur.
- HALT:
  - Ignore instr_valid, we and pc_update; no writes; pc held.
  - Register reads stay functional.
  - resume=1 → RUN with pc<=err_pc+PC_STEP, so the faulting instruction is skipped; err_cause<=00; err_pc held.
- resume outside HALT: ignored.
- Reads:
  - Combinational, no bypass; same-cycle writes become visible after the edge.
  - Address 0 or address ≥ NUM_REGS reads 0.
- Reset mid-operation: rst wins over every event, including resume, hata and a pending write; all values return to their reset values.
- retire is registered: high exactly the cycle after a commit edge.

Decomposition:
- Shared package core_pkg:
  - Enum wb_state_t {IDLE, RUN, HALT}.
  - Enum err_cause_t {ERR_NONE=2'b00, ERR_EXEC=2'b01, ERR_ALIGN=2'b10}.
  - Constant REG_ADDR_W=5.
- One sub-module, register_file (NUM_REGS×DATA_W):
  - Two combinational read ports, one synchronous write port.
  - Register 0 forced to zero.
- PC, state machine and counters stay in writeback_pc_unit.

Test Plan:
- Reset then run: rst high 2 cycles, then low, instr_valid=1, we=1, rd=3, sonuc=32'h1234 → reg3=32'h1234; pc goes 0→4; retire pulses; retire_cnt=1.
- Write to x0: rd=0, we=1, sonuc=32'hFFFF_FFFF → rs1_addr=0 reads 0; pc advances; retire_cnt increments.
- Taken branch: pc=8, pc_update=1, sonuc=32'h40, we=0 → pc=32'h40; no register changes.
- Misaligned branch: pc=32'h40, pc_update=1, sonuc=32'h42 → halted=1, err_cause=10, err_pc=32'h40; pc held; retire_cnt unchanged.
- Execute fault and resume: pc=32'h10, hata=1, we=1, rd=5 → reg5 unchanged, halted=1, err_cause=01; after 3 idle cycles pulse resume → pc=32'h14, halted=0, err_cause=00.
- Stall and wrap:
  - instr_valid=0 for 4 cycles → pc and retire_cnt constant.
  - Preload pc=32'hFFFF_FFFC, commit without branch → pc=0.
  - Assert rst together with resume in HALT → reset values.
